vma_xunit: RTL
==============

// Module: vma_xunit
// PURPOSE
// Parametrised virtual-memory-address unit for the EBOX. Next generation of the VMA board.
// Holds VMA, PC, VMA HELD and PREV SEC registers, and an incrementer/magic adder.
// Adds NBRK address-break channels, each with a pass counter and a sticky hit flag.
// Adds a registered diagnostic EBUS read port. Sits between EDP (AD bus), CON/MCL (control) and PAG/CSH.
// PARAMETERS
// ADDR_W  23  VMA bits 13:35; the low 18 bits are the in-section offset.
// SECT_W  5   section field width; ADDR_W-SECT_W must equal 18.
// NBRK    2   number of address-break channels, 1..8.
// CNT_W   8   width of each break pass counter.
// PORTS
// clk            in   1        EBOX VMA clock
// rst_n          in   1        asynchronous active-low reset
// ad             in   36       EDP AD[0:35]
// magic          in   9        CRAM MAGIC, two's complement
// vma_op         in   2        00 hold, 01 load, 10 inc, 11 pc+magic
// vmax_en        in   1        update the section field on load/magic
// vmax_sel       in   2        section source: 00 VMA, 01 PC, 10 PREV SEC, 11 AD
// extended       in   1        MCL VMA EXTENDED
// fetch          in   1        MCL VMA FETCH
// load_pc / load_held / load_prev_sec  in 1 each  register load strobes
// sel_held       in   1        held_or_pc selects HELD (1) or PC (0)
// ref_valid      in   1        memory reference issued this cycle
// ref_rd, ref_wr, ref_fetch  in 1 each  reference type
// brk_wr         in   1        write break channel brk_idx
// brk_idx        in   clog2(NBRK)  channel select
// brk_mode       in   3        {fetch,read,write} enables
// brk_cnt        in   CNT_W    pass count to load
// brk_ack        in   1        clear all hit flags
// diag_en        in   1        diagnostic read function active
// diag_sel       in   3        diagnostic word select
// vma, pc, held, held_or_pc   out ADDR_W
// prev_sec       out  SECT_W
// local_ref, ac_ref, local_ac  out 1
// brk_hit        out  NBRK     sticky per-channel hit
// brk_any        out  1        OR of brk_hit
// ebus_data      out  36       diagnostic data, zero when not driving
// ebus_drive     out  1        ebus_data is valid
// BEHAVIOUR
// - Reset: all registers, channel addr/mode/count, brk_hit, ebus_data and ebus_drive go to 0.
// - local = ~extended | fetch | (vma section <= 1). Combinational from registered VMA.
// - Load: offset <= ad[18:35]. If vmax_en, section <= sel mux (AD uses ad[13:17]); else section unchanged.
// - Inc: if local, offset+1 mod 2^18 and section held. Else full ADDR_W +1; all-ones wraps to 0.
// - Magic: offset <= pc offset + sext(magic) mod 2^18. Section handled as for load.
// - load_pc/load_held capture the pre-edge VMA, including when VMA updates in the same cycle.
// - load_prev_sec captures ad[13:17]. held_or_pc is combinational.
// - ac_ref = ref_valid & local & offset<16 & section<=1.
// - local_ac = local & offset<16 & section>1.
// - Break channel match: mode bit for the reference type set & channel addr == vma & ref_valid.
//   On match with count==0: hit set, count stays 0. On match with count!=0: count decremented, no hit.
// - brk_wr same cycle as a match on that channel: the write wins and no decrement/hit occurs.
// - brk_wr loads addr <= ad[13:35], mode and count.
// - brk_ack with a new hit in the same cycle: the new hit stays set, other bits clear.
// - Diag: ebus_data/ebus_drive registered, 1-cycle latency after diag_en/diag_sel.
//   sel 0 VMA, 1 PC, 2 HELD, 3 {prev_sec}, 4 {brk_hit, local_ac, ac_ref},
//   5..(4+NBRK) channel addr; unused selects read 0.
//   Words are right-justified to bit 35 (PDP numbering). Reset mid-read drops ebus_drive immediately.
// STRUCTURE
// - Package vma_x_pkg: vma_op_t, vmax_sel_t enums, brk_mode_t struct, OFS_W=18, diag select constants.
// - Sub-module vma_brk_chan holds addr/mode/counter/hit for one channel. Instantiated NBRK times via generate.
// TESTING
// - Reset mid-operation: assert rst_n low with counters nonzero -> all outputs 0 asynchronously,
//   before the next clk edge.
// - Local wrap: vma=0o0_777777, extended=0, inc -> vma=0o0_000000.
//   Global wrap: extended=1, section 3, offset 0o777777, inc -> section 4, offset 0.
// - Magic: pc offset 0o000005, magic=-7 -> offset 0o777776.
//   vmax_en=1, sel=PREV SEC(=0o12) -> section 0o12.
// - Break pass count: channel0 addr=0o1000, read mode, cnt=2, three reads at 0o1000
//   -> brk_hit[0] set only after the third.
//   Ack on the same cycle as a 4th hit -> bit stays set.
// - Capture ordering: load_pc and vma inc in the same cycle -> pc equals the old vma.
//   ac_ref=1 for offset 0o17 section 1; 0 for offset 0o20.
// - Diag: diag_en=1, sel=1 -> next cycle ebus_drive=1 and ebus_data[13:35]=pc.
//   diag_en=0 -> next cycle ebus_data=0.

Source files
------------

// File: rtl/vma_x_pkg.sv
// VMA unit shared types: op codes, section select, break modes.
// Diagnostic word selects and the magic-number sign extender.
package vma_x_pkg;

  localparam int OFS_W  = 18;
  localparam int EBUS_W = 36;

  typedef enum logic [1:0] {
    VOP_HOLD  = 2'b00,
    VOP_LOAD  = 2'b01,
    VOP_INC   = 2'b10,
    VOP_MAGIC = 2'b11
  } vma_op_t;

  typedef enum logic [1:0] {
    VSEL_VMA  = 2'b00,
    VSEL_PC   = 2'b01,
    VSEL_PREV = 2'b10,
    VSEL_AD   = 2'b11
  } vmax_sel_t;

  typedef struct packed {
    logic fetch;
    logic rd;
    logic wr;
  } brk_mode_t;

  localparam logic [2:0] DSEL_VMA  = 3'd0;
  localparam logic [2:0] DSEL_PC   = 3'd1;
  localparam logic [2:0] DSEL_HELD = 3'd2;
  localparam logic [2:0] DSEL_PSEC = 3'd3;
  localparam logic [2:0] DSEL_BRK  = 3'd4;
  localparam int         DSEL_CH0  = 5;

  function automatic logic [OFS_W-1:0] sext_magic(
    input logic [8:0] m
  );
    return {{(OFS_W-9){m[8]}}, m};
  endfunction

endpackage

// File: rtl/vma_xunit_if.sv
// Break-channel programming and diagnostic EBUS port of the VMA unit.
// master = control/diag side, slave = vma_xunit.
interface vma_xunit_if #(
  parameter int NBRK  = 2,
  parameter int CNT_W = 8,
  parameter int IDX_W = (NBRK > 1) ? $clog2(NBRK) : 1
);
  import vma_x_pkg::*;

  logic             brk_wr;
  logic [IDX_W-1:0] brk_idx;
  brk_mode_t        brk_mode;
  logic [CNT_W-1:0] brk_cnt;
  logic             brk_ack;
  logic [NBRK-1:0]  brk_hit;
  logic             brk_any;
  logic             diag_en;
  logic [2:0]       diag_sel;
  logic [35:0]      ebus_data;
  logic             ebus_drive;

  modport master (
    output brk_wr, brk_idx, brk_mode, brk_cnt, brk_ack,
    output diag_en, diag_sel,
    input  brk_hit, brk_any, ebus_data, ebus_drive
  );

  modport slave (
    input  brk_wr, brk_idx, brk_mode, brk_cnt, brk_ack,
    input  diag_en, diag_sel,
    output brk_hit, brk_any, ebus_data, ebus_drive
  );

endinterface

// File: rtl/vma_brk_chan.sv
// One address-break channel: address, mode, pass counter, sticky hit.
// A write to the channel takes priority over a match in the same cycle.
module vma_brk_chan
  import vma_x_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  brk_mode_t         wr_mode,
  input  logic [CNT_W-1:0]  wr_cnt,
  input  logic              ack,
  input  logic              ref_valid,
  input  logic              ref_rd,
  input  logic              ref_wr,
  input  logic              ref_fetch,
  input  logic [ADDR_W-1:0] vma,
  output logic [ADDR_W-1:0] addr,
  output logic              hit
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  brk_mode_t         mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hit_q, hit_d;
  logic              type_ok;
  logic              match;

  // Match detect, then write > match > hold; ack clears the old hit only.
  always_comb begin
    addr_d  = addr_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q & ~ack;
    type_ok = (mode_q.fetch & ref_fetch)
            | (mode_q.rd & ref_rd)
            | (mode_q.wr & ref_wr);
    match   = ref_valid & type_ok & (addr_q == vma);
    if (wr_en) begin
      addr_d = wr_addr;
      mode_d = wr_mode;
      cnt_d  = wr_cnt;
    end else if (match) begin
      if (cnt_q == '0) begin
        hit_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      mode_q <= '0;
      cnt_q  <= '0;
      hit_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      hit_q  <= hit_d;
    end
  end

  assign addr = addr_q;
  assign hit  = hit_q;

endmodule

// File: rtl/vma_xunit.sv
// EBOX VMA unit: VMA/PC/HELD/PREV SEC, incrementer and magic adder,
// address-break channels and a registered diagnostic EBUS read port.
module vma_xunit
  import vma_x_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter int SECT_W = 5,
  parameter int NBRK   = 2,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [35:0]       ad,
  input  logic [8:0]        magic,
  input  logic [1:0]        vma_op,
  input  logic              vmax_en,
  input  logic [1:0]        vmax_sel,
  input  logic              extended,
  input  logic              fetch,
  input  logic              load_pc,
  input  logic              load_held,
  input  logic              load_prev_sec,
  input  logic              sel_held,
  input  logic              ref_valid,
  input  logic              ref_rd,
  input  logic              ref_wr,
  input  logic              ref_fetch,
  output logic [ADDR_W-1:0] vma,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] held,
  output logic [ADDR_W-1:0] held_or_pc,
  output logic [SECT_W-1:0] prev_sec,
  output logic              local_ref,
  output logic              ac_ref,
  output logic              local_ac,
  vma_xunit_if.slave        bus
);

  localparam int IDX_W = (NBRK > 1) ? $clog2(NBRK) : 1;

  // Vectors are LSB-0: PDP bit 35 is bit 0 here, so ad[13:35] is ad[22:0].
  logic [ADDR_W-1:0] vma_q, vma_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] held_q, held_d;
  logic [SECT_W-1:0] psec_q, psec_d;
  logic [35:0]       ebus_q, ebus_d;
  logic              drv_q, drv_d;

  logic [SECT_W-1:0] vma_sec;
  logic [OFS_W-1:0]  vma_ofs;
  logic [SECT_W-1:0] ad_sec;
  logic [SECT_W-1:0] sec_mux;
  logic [SECT_W-1:0] ld_sec;
  logic              is_local;
  logic              low_ofs;
  logic [NBRK-1:0]   hit;
  logic [ADDR_W-1:0] ch_addr [NBRK];
  logic              unused_ad;

  assign vma_sec   = vma_q[ADDR_W-1:OFS_W];
  assign vma_ofs   = vma_q[OFS_W-1:0];
  assign ad_sec    = ad[ADDR_W-1:OFS_W];
  assign unused_ad = ^ad[35:ADDR_W];

  assign is_local = ~extended | fetch | (vma_sec <= SECT_W'(1));
  assign low_ofs  = vma_ofs < OFS_W'(16);

  // Section source for load and magic when vmax_en is set.
  always_comb begin
    sec_mux = vma_sec;
    unique case (vmax_sel_t'(vmax_sel))
      VSEL_VMA:  sec_mux = vma_sec;
      VSEL_PC:   sec_mux = pc_q[ADDR_W-1:OFS_W];
      VSEL_PREV: sec_mux = psec_q;
      VSEL_AD:   sec_mux = ad_sec;
      default:   sec_mux = vma_sec;
    endcase
    ld_sec = vmax_en ? sec_mux : vma_sec;
  end

  // VMA next value; PC/HELD sample the pre-edge VMA.
  always_comb begin
    vma_d = vma_q;
    unique case (vma_op_t'(vma_op))
      VOP_HOLD:  vma_d = vma_q;
      VOP_LOAD:  vma_d = {ld_sec, ad[OFS_W-1:0]};
      VOP_INC:   vma_d = is_local
                       ? {vma_sec, vma_ofs + OFS_W'(1)}
                       : vma_q + ADDR_W'(1);
      VOP_MAGIC: vma_d = {ld_sec,
                          pc_q[OFS_W-1:0] + sext_magic(magic)};
      default:   vma_d = vma_q;
    endcase
    pc_d   = load_pc ? vma_q : pc_q;
    held_d = load_held ? vma_q : held_q;
    psec_d = load_prev_sec ? ad_sec : psec_q;
  end

  // Diagnostic word select, registered for one cycle of latency.
  always_comb begin
    ebus_d = '0;
    drv_d  = bus.diag_en;
    if (bus.diag_en) begin
      case (bus.diag_sel)
        DSEL_VMA:  ebus_d = EBUS_W'(vma_q);
        DSEL_PC:   ebus_d = EBUS_W'(pc_q);
        DSEL_HELD: ebus_d = EBUS_W'(held_q);
        DSEL_PSEC: ebus_d = EBUS_W'(psec_q);
        DSEL_BRK:  ebus_d = EBUS_W'({hit, local_ac, ac_ref});
        default: begin
          for (int i = 0; i < NBRK; i++) begin
            if (int'(bus.diag_sel) == DSEL_CH0 + i) begin
              ebus_d = EBUS_W'(ch_addr[i]);
            end
          end
        end
      endcase
    end
  end

  // Architectural and EBUS registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vma_q  <= '0;
      pc_q   <= '0;
      held_q <= '0;
      psec_q <= '0;
      ebus_q <= '0;
      drv_q  <= 1'b0;
    end else begin
      vma_q  <= vma_d;
      pc_q   <= pc_d;
      held_q <= held_d;
      psec_q <= psec_d;
      ebus_q <= ebus_d;
      drv_q  <= drv_d;
    end
  end

  for (genvar i = 0; i < NBRK; i++) begin : g_ch
    vma_brk_chan #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (bus.brk_wr && (bus.brk_idx == IDX_W'(i))),
      .wr_addr   (ad[ADDR_W-1:0]),
      .wr_mode   (bus.brk_mode),
      .wr_cnt    (bus.brk_cnt),
      .ack       (bus.brk_ack),
      .ref_valid (ref_valid),
      .ref_rd    (ref_rd),
      .ref_wr    (ref_wr),
      .ref_fetch (ref_fetch),
      .vma       (vma_q),
      .addr      (ch_addr[i]),
      .hit       (hit[i])
    );
  end

  assign vma        = vma_q;
  assign pc         = pc_q;
  assign held       = held_q;
  assign held_or_pc = sel_held ? held_q : pc_q;
  assign prev_sec   = psec_q;
  assign local_ref  = is_local;
  assign ac_ref     = ref_valid & is_local & low_ofs
                    & (vma_sec <= SECT_W'(1));
  assign local_ac   = is_local & low_ofs
                    & (vma_sec > SECT_W'(1));

  assign bus.brk_hit    = hit;
  assign bus.brk_any    = |hit;
  assign bus.ebus_data  = ebus_q;
  assign bus.ebus_drive = drv_q;

endmodule
